// File: rtl/wb_sram_pkg.sv
// Shared definitions for the Wishbone-to-asynchronous-SRAM responder.
package wb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WS_W = 4;

endpackage

// File: rtl/wb_sram_ws_timer.sv
// Loadable down-counter that times the SRAM strobe; o_zero marks the last strobe cycle.
module wb_sram_ws_timer
  import wb_sram_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [WS_W-1:0] i_load_val,
  input  logic            i_dec,
  output logic            o_zero
);

  logic [WS_W-1:0] count_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_reg <= '0;
    end else if (i_load) begin
      count_reg <= i_load_val;
    end else if (i_dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign o_zero = (count_reg == '0);

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone pipelined responder driving an asynchronous SRAM, one transfer at a time,
// with an optional write-protect window that turns a region into ROM.
module wb_sram_slave
  import wb_sram_pkg::*;
#(
  parameter int                    WIDTH       = 8,
  parameter int                    ADDR_LINES  = 16,
  parameter int                    WAIT_STATES = 1,
  parameter logic [ADDR_LINES-1:0] WP_BASE     = 16'hF000,
  parameter logic [ADDR_LINES-1:0] WP_LAST     = 16'hFFFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [ADDR_LINES-1:0] i_wb_addr,
  input  logic [WIDTH-1:0]      i_wb_data,
  output logic                  o_wb_ack,
  output logic                  o_wb_stall,
  output logic [WIDTH-1:0]      o_wb_data,
  input  logic                  i_wp_en,
  output logic                  o_wp_hit,
  output logic [ADDR_LINES-1:0] o_sram_addr,
  output logic [WIDTH-1:0]      o_sram_dq_out,
  output logic                  o_sram_dq_oe,
  input  logic [WIDTH-1:0]      i_sram_dq_in,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_we_n
);

  state_t state_reg;
  state_t state_next;
  logic   we_reg;
  logic   wp_reg;
  logic   cyc_ok_reg;
  logic   ws_zero;
  logic   accept;
  logic   win_hit;

  assign accept     = (state_reg == IDLE) && i_wb_cyc && i_wb_stb;
  assign o_wb_stall = (state_reg != IDLE);

  // Plain unsigned compares: a reversed window never hits and an all-ones top cannot wrap.
  assign win_hit = (i_wb_addr >= WP_BASE) && (i_wb_addr <= WP_LAST);

  wb_sram_ws_timer u_ws_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (state_reg == SETUP),
    .i_load_val (WS_W'(WAIT_STATES)),
    .i_dec      (state_reg == PULSE),
    .o_zero     (ws_zero)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = PULSE;
      PULSE:   if (ws_zero) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      wp_reg        <= 1'b0;
      cyc_ok_reg    <= 1'b0;
      o_wb_ack      <= 1'b0;
      o_wp_hit      <= 1'b0;
      o_wb_data     <= '0;
      o_sram_addr   <= '0;
      o_sram_dq_out <= '0;
      o_sram_dq_oe  <= 1'b0;
      o_sram_ce_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
    end else begin
      state_reg <= state_next;
      o_wb_ack  <= 1'b0;
      o_wp_hit  <= 1'b0;
      // A master that lets go of cyc at any point forfeits the ack, but the SRAM cycle runs on.
      if ((state_reg != IDLE) && !i_wb_cyc) cyc_ok_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            o_sram_addr   <= i_wb_addr;
            o_sram_dq_out <= i_wb_data;
            we_reg        <= i_wb_we;
            wp_reg        <= i_wb_we && i_wp_en && win_hit;
            cyc_ok_reg    <= 1'b1;
            o_sram_ce_n   <= 1'b0;
            o_sram_oe_n   <= i_wb_we;
            o_sram_we_n   <= 1'b1;
            o_sram_dq_oe  <= i_wb_we;
          end
        end
        SETUP: begin
          o_sram_we_n <= ~(we_reg & ~wp_reg);
        end
        PULSE: begin
          if (ws_zero) begin
            o_sram_ce_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            o_sram_we_n <= 1'b1;
            if (!we_reg) o_wb_data <= i_sram_dq_in;
            o_wb_ack <= cyc_ok_reg & i_wb_cyc;
            o_wp_hit <= wp_reg & cyc_ok_reg & i_wb_cyc;
          end
        end
        DONE: begin
          o_sram_dq_oe <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: SRAM model, reference memory, per-feature scenarios.
module tb_wb_sram_slave;

  localparam int          WS     = 2;
  localparam int          NCYC   = WS + 6;
  localparam logic [15:0] WIN_LO = 16'hF000;
  localparam logic [15:0] WIN_HI = 16'hFFFF;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ack, stall, wp_en, wp_hit;
  logic [7:0]  rdata;
  logic [15:0] s_addr;
  logic [7:0]  s_dq_out, s_dq_in;
  logic        s_dq_oe, ce_n, oe_n, we_n;

  int checks = 0;
  int errors = 0;

  wb_sram_slave #(
    .WIDTH       (8),
    .ADDR_LINES  (16),
    .WAIT_STATES (WS),
    .WP_BASE     (WIN_LO),
    .WP_LAST     (WIN_HI)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wb_cyc      (cyc),
    .i_wb_stb      (stb),
    .i_wb_we       (we),
    .i_wb_addr     (addr),
    .i_wb_data     (wdata),
    .o_wb_ack      (ack),
    .o_wb_stall    (stall),
    .o_wb_data     (rdata),
    .i_wp_en       (wp_en),
    .o_wp_hit      (wp_hit),
    .o_sram_addr   (s_addr),
    .o_sram_dq_out (s_dq_out),
    .o_sram_dq_oe  (s_dq_oe),
    .i_sram_dq_in  (s_dq_in),
    .o_sram_ce_n   (ce_n),
    .o_sram_oe_n   (oe_n),
    .o_sram_we_n   (we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM model with a backdoor load port for preloading contents.
  logic [7:0]  sram_mem [0:65535];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;
  int          contention = 0;

  always @(posedge clk) begin
    if (bd_we) sram_mem[bd_addr] <= bd_data;
    else if (!ce_n && !we_n && s_dq_oe) sram_mem[s_addr] <= s_dq_out;
  end
  assign s_dq_in = (!ce_n && !oe_n) ? sram_mem[s_addr] : 8'h00;

  always @(negedge clk) begin
    if (!ce_n && !oe_n && s_dq_oe) contention++;
  end

  // Reference model: what memory and the read-data register should hold.
  logic [7:0] ref_mem [0:65535];
  logic [7:0] ref_last_read;

  function automatic logic is_guarded(input logic [15:0] a, input logic en);
    return en && (a >= WIN_LO) && (a <= WIN_HI);
  endfunction

  function automatic logic [NCYC-1:0] span(input int lo, input int hi);
    logic [NCYC-1:0] m = '0;
    for (int i = 0; i < NCYC; i++) if (i >= lo && i <= hi) m[i] = 1'b1;
    return m;
  endfunction

  // Per-cycle trace of one transfer; bit k = cycle k, where cycle 0 ends with the accept edge.
  logic [NCYC-1:0] tr_oe, tr_we, tr_dqoe, tr_ack, tr_stall, tr_hit, tr_ce;
  logic [7:0]      tr_data;

  task automatic bd_load(input logic [15:0] a, input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(posedge clk); #1;
    bd_we      = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic xfer(input logic w, input logic [15:0] a, input logic [7:0] d,
                      input logic wpe, input int drop_at, input logic flip_wp);
    tr_oe = '0; tr_we = '0; tr_dqoe = '0; tr_ack = '0; tr_stall = '0; tr_hit = '0; tr_ce = '0;
    tr_data = 8'h00;
    we = w; addr = a; wdata = d; wp_en = wpe; cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < NCYC; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == 1) begin
          stb = 1'b0;
          if (flip_wp) wp_en = ~wpe;
        end
        if (k == drop_at) cyc = 1'b0;
      end
      tr_oe[k] = ~oe_n; tr_we[k] = ~we_n; tr_dqoe[k] = s_dq_oe; tr_ack[k] = ack;
      tr_stall[k] = stall; tr_hit[k] = wp_hit; tr_ce[k] = ~ce_n;
      if (ack) tr_data = rdata;
      if (k == WS + 3) cyc = 1'b0;
    end
    wp_en = wpe;
    $display("xfer we=%0d addr=%h wdata=%h wp_en=%0d ack=%b hit=%b rdata=%h",
             w, a, d, wpe, tr_ack, tr_hit, tr_data);
  endtask

  task automatic test_reset;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; wp_en = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ce_n !== 1'b1) begin errors++; $display("FAIL rst_in_ce_n: got %b want 1", ce_n); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
    checks++; if (ack !== 1'b0 || wp_hit !== 1'b0) begin errors++; $display("FAIL rst_ack_hit: got %b%b want 00", ack, wp_hit); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", rdata); end
    checks++; if ({ce_n, oe_n, we_n, s_dq_oe} !== 4'b1110) begin errors++; $display("FAIL rst_sram_ctl: got %b want 1110", {ce_n, oe_n, we_n, s_dq_oe}); end
    checks++; if (s_addr !== 16'h0000 || s_dq_out !== 8'h00) begin errors++; $display("FAIL rst_sram_bus: got %h/%h want 0000/00", s_addr, s_dq_out); end
    ref_last_read = 8'h00;
  endtask

  task automatic test_read;
    logic [15:0] a;
    logic [7:0]  d;
    bd_load(16'h1234, 8'hA5);
    xfer(1'b0, 16'h1234, 8'h00, 1'b0, -1, 1'b0);
    checks++; if (tr_oe !== span(1, WS + 2)) begin errors++; $display("FAIL read_oe: got %b want %b", tr_oe, span(1, WS + 2)); end
    checks++; if (tr_ce !== span(1, WS + 2)) begin errors++; $display("FAIL read_ce: got %b want %b", tr_ce, span(1, WS + 2)); end
    checks++; if (tr_ack !== span(WS + 3, WS + 3)) begin errors++; $display("FAIL read_ack: got %b want %b", tr_ack, span(WS + 3, WS + 3)); end
    checks++; if (tr_stall !== span(1, WS + 3)) begin errors++; $display("FAIL read_stall: got %b want %b", tr_stall, span(1, WS + 3)); end
    checks++; if (tr_we !== '0 || tr_dqoe !== '0) begin errors++; $display("FAIL read_no_drive: got we=%b oe=%b want 0", tr_we, tr_dqoe); end
    checks++; if (tr_data !== 8'hA5) begin errors++; $display("FAIL read_data: got %h want a5", tr_data); end
    ref_last_read = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom);
      d = 8'($urandom);
      bd_load(a, d);
      xfer(1'b0, a, 8'h00, 1'($urandom), -1, 1'b0);
      checks++; if (tr_data !== ref_mem[a] || tr_ack !== span(WS + 3, WS + 3)) begin
        errors++; $display("FAIL read_rand: got %h ack %b want %h ack %b", tr_data, tr_ack, ref_mem[a], span(WS + 3, WS + 3));
      end
      checks++; if (tr_hit !== '0) begin errors++; $display("FAIL read_rand_hit: got %b want 0", tr_hit); end
      ref_last_read = ref_mem[a];
    end
  endtask

  task automatic test_write;
    logic [15:0] a;
    logic [7:0]  d;
    logic        e;
    xfer(1'b1, 16'h0010, 8'h3C, 1'b0, -1, 1'b0);
    ref_mem[16'h0010] = 8'h3C;
    checks++; if (tr_we !== span(2, WS + 2)) begin errors++; $display("FAIL write_we: got %b want %b", tr_we, span(2, WS + 2)); end
    checks++; if (tr_dqoe !== span(1, WS + 3)) begin errors++; $display("FAIL write_dqoe: got %b want %b", tr_dqoe, span(1, WS + 3)); end
    checks++; if (tr_ack !== span(WS + 3, WS + 3)) begin errors++; $display("FAIL write_ack: got %b want %b", tr_ack, span(WS + 3, WS + 3)); end
    checks++; if (tr_oe !== '0 || tr_hit !== '0) begin errors++; $display("FAIL write_oe_hit: got %b/%b want 0", tr_oe, tr_hit); end
    checks++; if (rdata !== ref_last_read) begin errors++; $display("FAIL write_rdata_hold: got %h want %h", rdata, ref_last_read); end
    xfer(1'b0, 16'h0010, 8'h00, 1'b0, -1, 1'b0);
    checks++; if (tr_data !== 8'h3C) begin errors++; $display("FAIL write_readback: got %h want 3c", tr_data); end
    ref_last_read = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom_range(0, 16'hEFFF));
      d = 8'($urandom);
      e = 1'($urandom);
      xfer(1'b1, a, d, e, -1, 1'b0);
      if (!is_guarded(a, e)) ref_mem[a] = d;
      checks++; if (tr_we !== span(2, WS + 2) || tr_ack !== span(WS + 3, WS + 3)) begin
        errors++; $display("FAIL write_rand_strobe: got we %b ack %b", tr_we, tr_ack);
      end
      xfer(1'b0, a, 8'h00, 1'b0, -1, 1'b0);
      checks++; if (tr_data !== ref_mem[a]) begin errors++; $display("FAIL write_rand_readback: got %h want %h", tr_data, ref_mem[a]); end
      ref_last_read = ref_mem[a];
    end
  endtask

  task automatic test_write_protect;
    logic [15:0] addrs [4];
    logic        g;
    addrs[0] = 16'hF800; addrs[1] = 16'hEFFF; addrs[2] = 16'hF000; addrs[3] = 16'hFFFF;
    bd_load(16'hF800, 8'h5A);
    xfer(1'b1, 16'hF800, 8'hFF, 1'b1, -1, 1'b1);
    checks++; if (tr_we !== '0) begin errors++; $display("FAIL wp_we: got %b want 0", tr_we); end
    checks++; if (tr_ack !== span(WS + 3, WS + 3) || tr_hit !== span(WS + 3, WS + 3)) begin
      errors++; $display("FAIL wp_ack_hit: got ack %b hit %b want %b", tr_ack, tr_hit, span(WS + 3, WS + 3));
    end
    xfer(1'b0, 16'hF800, 8'h00, 1'b1, -1, 1'b0);
    checks++; if (tr_data !== 8'h5A || tr_hit !== '0) begin errors++; $display("FAIL wp_readback: got %h hit %b want 5a hit 0", tr_data, tr_hit); end
    ref_last_read = 8'h5A;
    xfer(1'b1, 16'hF800, 8'hFF, 1'b0, -1, 1'b1);
    ref_mem[16'hF800] = 8'hFF;
    checks++; if (tr_we !== span(2, WS + 2) || tr_hit !== '0) begin errors++; $display("FAIL wp_off_we: got we %b hit %b", tr_we, tr_hit); end
    for (int i = 0; i < 4; i++) begin
      bd_load(addrs[i], 8'($urandom));
      g = is_guarded(addrs[i], 1'b1);
      xfer(1'b1, addrs[i], 8'($urandom), 1'b1, -1, 1'b0);
      if (!g) ref_mem[addrs[i]] = wdata;
      checks++; if (tr_hit !== (g ? span(WS + 3, WS + 3) : '0) || tr_we !== (g ? '0 : span(2, WS + 2))) begin
        errors++; $display("FAIL wp_window %h: got hit %b we %b guarded %0d", addrs[i], tr_hit, tr_we, g);
      end
      xfer(1'b0, addrs[i], 8'h00, 1'b1, -1, 1'b0);
      checks++; if (tr_data !== ref_mem[addrs[i]]) begin errors++; $display("FAIL wp_window_rb %h: got %h want %h", addrs[i], tr_data, ref_mem[addrs[i]]); end
      ref_last_read = ref_mem[addrs[i]];
    end
  endtask

  task automatic test_back_to_back;
    logic        r_we [4];
    logic [15:0] r_a  [4];
    logic [7:0]  r_d  [4];
    logic [7:0]  exp_data [4];
    int          acc_c [4];
    int          ack_c [4];
    int          idx, nacks;
    for (int i = 0; i < 4; i++) begin
      r_we[i] = i[0];
      r_a[i]  = 16'($urandom_range(0, 16'hEFFF));
      r_d[i]  = 8'($urandom);
      if (!r_we[i]) bd_load(r_a[i], 8'($urandom));
    end
    for (int i = 0; i < 4; i++) begin
      if (r_we[i]) ref_mem[r_a[i]] = r_d[i];
      else ref_last_read = ref_mem[r_a[i]];
      exp_data[i] = ref_last_read;
      acc_c[i] = -1; ack_c[i] = -1;
    end
    idx = 0; nacks = 0;
    we = r_we[0]; addr = r_a[0]; wdata = r_d[0]; wp_en = 1'b0; cyc = 1'b1; stb = 1'b1;
    for (int c = 0; c < 4 * (WS + 4) + 20 && nacks < 4; c++) begin
      logic will_acc;
      will_acc = !stall && stb;
      @(posedge clk); #1;
      if (will_acc) begin
        acc_c[idx] = c;
        idx++;
        if (idx < 4) begin we = r_we[idx]; addr = r_a[idx]; wdata = r_d[idx]; end
        else stb = 1'b0;
      end
      if (ack) begin
        ack_c[nacks] = c + 1;
        $display("b2b ack %0d cycle %0d rdata=%h", nacks, c + 1, rdata);
        checks++; if (rdata !== exp_data[nacks] || stall !== 1'b1) begin
          errors++; $display("FAIL b2b_data %0d: got %h stall %b want %h stall 1", nacks, rdata, stall, exp_data[nacks]);
        end
        nacks++;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (nacks != 4 || idx != 4) begin errors++; $display("FAIL b2b_count: got acks %0d accepts %0d want 4 4", nacks, idx); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ack_c[i] - acc_c[i] != WS + 3) begin errors++; $display("FAIL b2b_latency %0d: got %0d want %0d", i, ack_c[i] - acc_c[i], WS + 3); end
      if (i > 0) begin
        checks++; if (ack_c[i] - ack_c[i-1] != WS + 4) begin errors++; $display("FAIL b2b_spacing %0d: got %0d want %0d", i, ack_c[i] - ack_c[i-1], WS + 4); end
      end
    end
  endtask

  task automatic test_drop_cyc;
    logic [15:0] a;
    logic [7:0]  d;
    a = 16'($urandom_range(0, 16'hEFFF));
    d = 8'($urandom);
    xfer(1'b1, a, d, 1'b0, 2, 1'b0);
    ref_mem[a] = d;
    checks++; if (tr_we !== span(2, WS + 2)) begin errors++; $display("FAIL drop_we: got %b want %b", tr_we, span(2, WS + 2)); end
    checks++; if (tr_ack !== '0 || tr_hit !== '0) begin errors++; $display("FAIL drop_ack: got %b/%b want 0", tr_ack, tr_hit); end
    checks++; if (tr_stall !== span(1, WS + 3)) begin errors++; $display("FAIL drop_stall: got %b want %b", tr_stall, span(1, WS + 3)); end
    xfer(1'b0, a, 8'h00, 1'b0, -1, 1'b0);
    checks++; if (tr_data !== d || tr_ack !== span(WS + 3, WS + 3)) begin errors++; $display("FAIL drop_next: got %h ack %b want %h", tr_data, tr_ack, d); end
    ref_last_read = d;
  endtask

  task automatic test_reset_mid;
    logic [15:0] a, b;
    logic [7:0]  e;
    int          spurious;
    a = 16'($urandom_range(0, 16'hEFFF));
    b = a ^ 16'h0001;
    e = 8'($urandom);
    we = 1'b1; addr = a; wdata = 8'($urandom); wp_en = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (we_n !== 1'b0) begin errors++; $display("FAIL rmid_in_pulse: got we_n %b want 0", we_n); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({we_n, ce_n, oe_n, s_dq_oe} !== 4'b1110) begin errors++; $display("FAIL rmid_sram: got %b want 1110", {we_n, ce_n, oe_n, s_dq_oe}); end
    checks++; if (ack !== 1'b0 || stall !== 1'b0 || rdata !== 8'h00) begin errors++; $display("FAIL rmid_wb: got ack %b stall %b rdata %h want 0 0 00", ack, stall, rdata); end
    rst = 1'b0; cyc = 1'b0;
    ref_last_read = 8'h00;
    spurious = 0;
    for (int i = 0; i < WS + 6; i++) begin
      @(posedge clk); #1;
      if (ack) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rmid_no_ack: got %0d acks want 0", spurious); end
    bd_load(b, e);
    xfer(1'b0, b, 8'h00, 1'b0, -1, 1'b0);
    checks++; if (tr_data !== e || tr_ack !== span(WS + 3, WS + 3)) begin errors++; $display("FAIL rmid_next_read: got %h ack %b want %h", tr_data, tr_ack, e); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_write_protect();
    test_back_to_back();
    test_drop_cyc();
    test_reset_mid();
    checks++; if (contention != 0) begin errors++; $display("FAIL bus_contention: got %0d cycles want 0", contention); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_sram_slave.md
Name: wb_sram_slave

Overview:
- Wishbone pipelined-mode responder (slave) that answers the S100-to-Wishbone bridge master and drives an external asynchronous SRAM.
- Each accepted request becomes one SRAM read or write cycle with a parameterised number of wait states.
- An optional write-protect window makes a region behave as ROM: writes to it are acknowledged but not performed.

Parameters:
- WIDTH, 8, data width of the Wishbone bus and the SRAM.
- ADDR_LINES, 16, address width of the Wishbone bus and the SRAM.
- WAIT_STATES, 1, extra SRAM strobe cycles; strobe length = WAIT_STATES+1 cycles; legal range 0..15.
- WP_BASE, 16'hF000, first address of the write-protect window.
- WP_LAST, 16'hFFFF, last address of the window (inclusive).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_wb_cyc  in  1  Wishbone cycle.
- i_wb_stb  in  1  Wishbone strobe.
- i_wb_we  in  1  1 = write.
- i_wb_addr  in  ADDR_LINES  request address.
- i_wb_data  in  WIDTH  write data.
- o_wb_ack  out  1  one-cycle acknowledge.
- o_wb_stall  out  1  request not accepted this cycle.
- o_wb_data  out  WIDTH  read data, valid while o_wb_ack=1.
- i_wp_en  in  1  enables the write-protect window.
- o_wp_hit  out  1  one-cycle pulse, coincident with ack, for a suppressed write.
- o_sram_addr  out  ADDR_LINES  SRAM address.
- o_sram_dq_out  out  WIDTH  data driven to SRAM.
- o_sram_dq_oe  out  1  tristate enable for o_sram_dq_out.
- i_sram_dq_in  in  WIDTH  data from SRAM.
- o_sram_ce_n  out  1  chip enable, active low.
- o_sram_oe_n  out  1  output enable, active low.
- o_sram_we_n  out  1  write enable, active low.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - o_wb_ack=0, o_wp_hit=0, o_wb_data=0.
  - o_sram_ce_n=1, o_sram_oe_n=1, o_sram_we_n=1, o_sram_dq_oe=0.
  - o_sram_addr=0, o_sram_dq_out=0.
- Reset asserted mid-transaction: abandons the cycle at the next edge and drives all of the above values. No ack is issued for the abandoned request.
- o_wb_stall = (state != IDLE), combinational from state. o_wb_stall=0 in IDLE, including immediately after reset.
- Accept condition: IDLE & i_wb_cyc & i_wb_stb. On accept:
  - Latch addr, we and data into o_sram_addr / o_sram_dq_out.
  - Latch wp = we & i_wp_en & (WP_BASE <= addr <= WP_LAST), inclusive compare, unsigned.
  - Go to SETUP.
- SETUP (1 cycle):
  - ce_n=0.
  - Read: oe_n=0, dq_oe=0.
  - Write: dq_oe=1, we_n=1.
  - Load counter = WAIT_STATES. Go to PULSE.
- PULSE (WAIT_STATES+1 cycles):
  - ce_n=0.
  - Read: oe_n=0.
  - Write: we_n = wp ? 1 : 0; dq_oe=1.
  - Counter decrements each cycle. When counter==0: read captures i_sram_dq_in into o_wb_data at that edge; go to DONE.
- DONE (1 cycle):
  - we_n=1, oe_n=1, ce_n=1.
  - dq_oe stays 1 for writes (data hold); dq_oe=0 at exit.
  - o_wb_ack=1 if i_wb_cyc is still high; o_wp_hit=wp & ack.
  - Go to IDLE.
- Latency (accept edge = cycle 0):
  - ack in cycle WAIT_STATES+3.
  - Next accept possible in cycle WAIT_STATES+4.
  - Throughput: one transfer per WAIT_STATES+4 cycles.
- Dropped cycle: i_wb_cyc falling while busy does not shorten the SRAM cycle (no truncated write pulse). The cycle completes and ack is suppressed. The next request is accepted only from IDLE.
- Requests presented while stall=1 are ignored and must be held by the master per Wishbone pipelined rules.
- No overlap: at most one transaction outstanding; ack never coincides with acceptance.
- o_wb_data holds the last read value between reads. Writes do not modify it.
- Address window: WP_BASE > WP_LAST means an empty window (never hits). WP_LAST=all-ones must not wrap.
- i_wp_en is sampled only at accept; changes mid-transaction have no effect.

Decomposition:
- Shared package wb_sram_pkg:
  - state enum {IDLE, SETUP, PULSE, DONE}, 2-bit encoding.
  - localparam WS_W=4, the counter width.
- Sub-module wb_sram_ws_timer: loadable down-counter with a zero flag, used for PULSE length.
- All remaining logic stays in one always block plus combinational stall.

Test Plan:
- Read, WAIT_STATES=2, SRAM model holding 8'hA5 at 16'h1234; request accepted at cycle 0 -> oe_n low cycles 1-4, ack=1 only in cycle 5 with o_wb_data=8'hA5, stall=1 cycles 1-5.
- Write 8'h3C to 16'h0010, WAIT_STATES=0 -> we_n low exactly 1 cycle (cycle 2), dq_oe=1 cycles 1-3, ack cycle 3, readback returns 8'h3C.
- i_wp_en=1, write 8'hFF to 16'hF800 -> we_n never low, ack and o_wp_hit both pulse once, readback returns the prior value. Same write with i_wp_en=0 updates memory. Write to 16'hEFFF is never protected.
- Back-to-back: master holds stb with 4 requests -> each accepted only when stall=0, exactly 4 acks, spacing WAIT_STATES+4 cycles, data in order.
- Drop i_wb_cyc in PULSE of a write -> full we_n pulse still produced, no ack, stall falls after DONE, next request serviced normally.
- Assert i_rst during PULSE of a write -> next edge: we_n=1, ce_n=1, dq_oe=0, ack=0, stall=0. Then a new read completes normally.
